unmix_color_engine: RTL and testbench

Streaming recovery engine that reverses the pixel mixing stage. It reads a mixed image and its key image pixel by pixel from two read ports. It writes each recovered pixel to an output memory port. Each recovered pixel is `original = mixed ^ key`, per 24-bit RGB pixel. It sits after the frame memories in the image datapath and is launched by the host controller with a one-cycle start pulse.

---
 rtl/unmix_color_engine.sv | 156 +++++++++++++++
 tb/tb_unmix_color_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unmix_color_engine.sv
`default_nettype none
// ============================================================================
//  Module   : unmix_color_engine
//  Purpose  : Streaming pixel recovery. Reads a mixed image and its key image
//             in lockstep and writes original = mixed ^ key for every 24-bit
//             RGB pixel. One pixel per cycle, two-stage datapath behind the
//             read ports.
//  Options  : UNMIX_CHECKSUM_EN - builds a running 24-bit sum of all written
//             pixels; without it the checksum output is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module unmix_color_engine #(
    parameter int PIX_NUM = 16384,
    parameter int ADDR_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mix_rd,
    output logic [ADDR_W-1:0] mix_addr,
    input  logic [23:0]       mix_data,
    output logic              key_rd,
    output logic [ADDR_W-1:0] key_addr,
    input  logic [23:0]       key_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [23:0]       checksum
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Final pixel address; truncation is exact even when PIX_NUM = 2^ADDR_W.
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(PIX_NUM - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_count;
    logic [1:0]        r_drain;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [23:0]       r_wr_data;
    logic              w_rd;
    logic              w_start_ok;

    assign w_rd       = (r_state == c_READ);
    assign w_start_ok = (r_state == c_IDLE) && start;

    // Control FSM: pixel counter advances once per READ cycle, then a fixed
    // two-cycle drain lets the last two reads reach the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_drain <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_READ;
                        r_count <= '0;
                    end
                end
                c_READ: begin
                    if (r_count == c_LAST_ADDR) begin
                        r_state <= c_DRAIN;
                        r_drain <= 2'd0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_DRAIN: begin
                    if (r_drain == 2'd1) begin
                        r_state <= c_DONE;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Both memories are addressed identically; address is forced to zero
    // outside READ so idle outputs stay quiet.
    assign mix_rd   = w_rd;
    assign key_rd   = w_rd;
    assign mix_addr = w_rd ? r_count : '0;
    assign key_addr = w_rd ? r_count : '0;

    // Stage 1: remember which address the in-flight read belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= w_rd;
            r_s1_addr  <= mix_addr;
        end
    end

    // Stage 2: unmix the returned pixel pair and present it to the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 24'h000000;
        end else begin
            r_wr_en <= r_s1_valid;
            if (r_s1_valid) begin
                r_wr_addr <= r_s1_addr;
                r_wr_data <= mix_data ^ key_data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state == c_READ) || (r_state == c_DRAIN);
    assign done    = (r_state == c_DONE);

`ifdef UNMIX_CHECKSUM_EN
    logic [23:0] r_checksum;

    // Running modulo-2^24 sum of written pixels; cleared when a run launches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 24'h000000;
        end else if (w_start_ok) begin
            r_checksum <= 24'h000000;
        end else if (r_wr_en) begin
            r_checksum <= r_checksum + r_wr_data;
        end
    end

    assign checksum = r_checksum;
`else
    logic w_unused_start_ok;
    assign w_unused_start_ok = w_start_ok;
    assign checksum = 24'h000000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unmix_color_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unmix_color_engine
//  Purpose  : Directed self-checking bench for unmix_color_engine. Four
//             instances cover PIX_NUM = 16, 4, 1 and 2 (the last with
//             ADDR_W = 1 so the final address is the top of the range).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unmix_color_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance p16: PIX_NUM=16, ADDR_W=4 -------------------
    logic        p16_start = 1'b0;
    logic        p16_mix_rd, p16_key_rd, p16_wr_en, p16_busy, p16_done;
    logic [3:0]  p16_mix_addr, p16_key_addr, p16_wr_addr;
    logic [23:0] p16_mix_data = '0, p16_key_data = '0, p16_wr_data, p16_checksum;
    logic [23:0] mix16 [16];
    logic [23:0] key16 [16];

    unmix_color_engine #(.PIX_NUM(16), .ADDR_W(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(p16_start),
        .mix_rd(p16_mix_rd), .mix_addr(p16_mix_addr), .mix_data(p16_mix_data),
        .key_rd(p16_key_rd), .key_addr(p16_key_addr), .key_data(p16_key_data),
        .wr_en(p16_wr_en), .wr_addr(p16_wr_addr), .wr_data(p16_wr_data),
        .busy(p16_busy), .done(p16_done), .checksum(p16_checksum));

    always @(posedge clk) begin
        if (p16_mix_rd) p16_mix_data <= mix16[p16_mix_addr];
        if (p16_key_rd) p16_key_data <= key16[p16_key_addr];
    end

    // ---------------- instance p4: PIX_NUM=4, ADDR_W=4 ---------------------
    logic        p4_start = 1'b0;
    logic        p4_mix_rd, p4_key_rd, p4_wr_en, p4_busy, p4_done;
    logic [3:0]  p4_mix_addr, p4_key_addr, p4_wr_addr;
    logic [23:0] p4_mix_data = '0, p4_key_data = '0, p4_wr_data, p4_checksum;
    logic [23:0] mix4 [4];
    logic [23:0] key4 [4];
    logic [23:0] exp4 [4];

    unmix_color_engine #(.PIX_NUM(4), .ADDR_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(p4_start),
        .mix_rd(p4_mix_rd), .mix_addr(p4_mix_addr), .mix_data(p4_mix_data),
        .key_rd(p4_key_rd), .key_addr(p4_key_addr), .key_data(p4_key_data),
        .wr_en(p4_wr_en), .wr_addr(p4_wr_addr), .wr_data(p4_wr_data),
        .busy(p4_busy), .done(p4_done), .checksum(p4_checksum));

    always @(posedge clk) begin
        if (p4_mix_rd) p4_mix_data <= mix4[p4_mix_addr[1:0]];
        if (p4_key_rd) p4_key_data <= key4[p4_key_addr[1:0]];
    end

    // ---------------- instance p1: PIX_NUM=1, ADDR_W=4 ---------------------
    logic        p1_start = 1'b0;
    logic        p1_mix_rd, p1_key_rd, p1_wr_en, p1_busy, p1_done;
    logic [3:0]  p1_mix_addr, p1_key_addr, p1_wr_addr;
    logic [23:0] p1_mix_data = '0, p1_key_data = '0, p1_wr_data, p1_checksum;

    unmix_color_engine #(.PIX_NUM(1), .ADDR_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(p1_start),
        .mix_rd(p1_mix_rd), .mix_addr(p1_mix_addr), .mix_data(p1_mix_data),
        .key_rd(p1_key_rd), .key_addr(p1_key_addr), .key_data(p1_key_data),
        .wr_en(p1_wr_en), .wr_addr(p1_wr_addr), .wr_data(p1_wr_data),
        .busy(p1_busy), .done(p1_done), .checksum(p1_checksum));

    always @(posedge clk) begin
        if (p1_mix_rd) p1_mix_data <= (p1_mix_addr == 4'd0) ? 24'h800001 : 24'h0;
        if (p1_key_rd) p1_key_data <= (p1_key_addr == 4'd0) ? 24'h000001 : 24'h0;
    end

    // ---------------- instance p2: PIX_NUM=2, ADDR_W=1 ---------------------
    logic        p2_start = 1'b0;
    logic        p2_mix_rd, p2_key_rd, p2_wr_en, p2_busy, p2_done;
    logic [0:0]  p2_mix_addr, p2_key_addr, p2_wr_addr;
    logic [23:0] p2_mix_data = '0, p2_key_data = '0, p2_wr_data, p2_checksum;

    unmix_color_engine #(.PIX_NUM(2), .ADDR_W(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(p2_start),
        .mix_rd(p2_mix_rd), .mix_addr(p2_mix_addr), .mix_data(p2_mix_data),
        .key_rd(p2_key_rd), .key_addr(p2_key_addr), .key_data(p2_key_data),
        .wr_en(p2_wr_en), .wr_addr(p2_wr_addr), .wr_data(p2_wr_data),
        .busy(p2_busy), .done(p2_done), .checksum(p2_checksum));

    // Recovered pixels FFFFFF then 000002.
    always @(posedge clk) begin
        if (p2_mix_rd) p2_mix_data <= p2_mix_addr[0] ? 24'h000003 : 24'hFFFFFF;
        if (p2_key_rd) p2_key_data <= p2_key_addr[0] ? 24'h000001 : 24'h000000;
    end

`ifdef UNMIX_CHECKSUM_EN
    localparam logic [23:0] c_EXP_SUM = 24'h000001;
`else
    localparam logic [23:0] c_EXP_SUM = 24'h000000;
`endif

    // ------------------------------------------------------------------------
    task automatic test_reset;
        checks++;
        if ({p4_mix_rd, p4_key_rd, p4_wr_en, p4_busy, p4_done, p4_mix_addr,
             p4_wr_addr, p4_wr_data, p4_checksum} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h required all zero",
                     {p4_mix_rd, p4_key_rd, p4_wr_en, p4_busy, p4_done,
                      p4_mix_addr, p4_wr_addr, p4_wr_data, p4_checksum});
        end
    endtask

    task automatic test_reset_mid_image;
        @(negedge clk); p16_start = 1'b1;
        @(negedge clk); p16_start = 1'b0;
        for (int c = 2; c <= 6; c++) @(negedge clk);
        // cycle 6: read of pixel 5 issued
        checks++;
        if (p16_mix_rd !== 1'b1 || p16_mix_addr !== 4'd5) begin
            errors++;
            $display("FAIL mid_read: rd=%b addr=%0d required rd=1 addr=5", p16_mix_rd, p16_mix_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({p16_mix_rd, p16_key_rd, p16_wr_en, p16_busy, p16_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: rd/rd/wr/busy/done=%b required 00000",
                     {p16_mix_rd, p16_key_rd, p16_wr_en, p16_busy, p16_done});
        end
        checks++;
        if ({p16_mix_addr, p16_key_addr, p16_wr_addr, p16_wr_data, p16_checksum} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr/data=%h required 0",
                     {p16_mix_addr, p16_key_addr, p16_wr_addr, p16_wr_data, p16_checksum});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (p16_busy !== 1'b0 || p16_mix_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b rd=%b required 0 0", p16_busy, p16_mix_rd);
        end
    endtask

    task automatic test_full_range;
        int idx = 0;
        logic [3:0] last_addr = '0;
        @(negedge clk); p16_start = 1'b1;
        @(negedge clk); p16_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (p16_wr_en !== (c >= 3 && c <= 18)) begin
                errors++;
                $display("FAIL full_wr_en c=%0d: got %b required %b", c, p16_wr_en, (c >= 3 && c <= 18));
            end
            if (p16_wr_en === 1'b1) begin
                checks++;
                if (p16_wr_addr !== idx[3:0] || p16_wr_data !== mix16[idx[3:0]]) begin
                    errors++;
                    $display("FAIL full_write #%0d: addr=%0d data=%h required addr=%0d data=%h",
                             idx, p16_wr_addr, p16_wr_data, idx, mix16[idx[3:0]]);
                end
                last_addr = p16_wr_addr;
                idx++;
            end
            checks++;
            if (p16_done !== (c == 19) || p16_busy !== (c <= 18)) begin
                errors++;
                $display("FAIL full_ctl c=%0d: done=%b busy=%b required %b %b",
                         c, p16_done, p16_busy, (c == 19), (c <= 18));
            end
        end
        checks++;
        if (idx != 16 || last_addr !== 4'd15) begin
            errors++;
            $display("FAIL full_count: writes=%0d last_addr=%0d required 16 15", idx, last_addr);
        end
    endtask

    task automatic test_basic;
        @(negedge clk); p4_start = 1'b1;
        @(negedge clk); p4_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (p4_mix_rd !== (c <= 4) || p4_key_rd !== (c <= 4) ||
                (c <= 4 && (p4_mix_addr !== 4'(c - 1) || p4_key_addr !== 4'(c - 1)))) begin
                errors++;
                $display("FAIL basic_read c=%0d: rd=%b%b addr=%0d/%0d", c, p4_mix_rd, p4_key_rd, p4_mix_addr, p4_key_addr);
            end
            checks++;
            if (p4_wr_en !== (c >= 3 && c <= 6) ||
                (c >= 3 && c <= 6 && (p4_wr_addr !== 4'(c - 3) || p4_wr_data !== exp4[c - 3]))) begin
                errors++;
                $display("FAIL basic_write c=%0d: en=%b addr=%0d data=%h", c, p4_wr_en, p4_wr_addr, p4_wr_data);
            end
            checks++;
            if (p4_done !== (c == 7) || p4_busy !== (c <= 6)) begin
                errors++;
                $display("FAIL basic_ctl c=%0d: done=%b busy=%b required %b %b", c, p4_done, p4_busy, (c == 7), (c <= 6));
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); p4_start = 1'b1;
        @(negedge clk); p4_start = 1'b0;
        for (int run = 0; run < 2; run++) begin
            for (int c = 1; c <= 8; c++) begin
                if (c > 1) @(negedge clk);
                if (run == 0 && c == 3) p4_start = 1'b0;
                checks++;
                if (p4_done !== (c == 7) || p4_busy !== (c <= 6) || p4_wr_en !== (c >= 3 && c <= 6)) begin
                    errors++;
                    $display("FAIL b2b_ctl run=%0d c=%0d: done=%b busy=%b wr_en=%b", run, c, p4_done, p4_busy, p4_wr_en);
                end
                if (p4_wr_en === 1'b1) begin
                    checks++;
                    if (p4_wr_data !== exp4[p4_wr_addr[1:0]] || p4_wr_addr !== 4'(c - 3)) begin
                        errors++;
                        $display("FAIL b2b_write run=%0d c=%0d: addr=%0d data=%h", run, c, p4_wr_addr, p4_wr_data);
                    end
                end
                if (run == 0 && c == 2) p4_start = 1'b1;   // ignored while busy
                if (run == 0 && c == 8) p4_start = 1'b1;   // IDLE cycle after done
            end
            if (run == 0) begin
                @(negedge clk); p4_start = 1'b0;
            end
        end
    endtask

    task automatic test_single;
        @(negedge clk); p1_start = 1'b1;
        @(negedge clk); p1_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (p1_mix_rd !== (c == 1) || p1_wr_en !== (c == 3) ||
                p1_done !== (c == 4) || p1_busy !== (c <= 3)) begin
                errors++;
                $display("FAIL single_ctl c=%0d: rd=%b wr_en=%b done=%b busy=%b", c, p1_mix_rd, p1_wr_en, p1_done, p1_busy);
            end
            if (c == 3) begin
                checks++;
                if (p1_wr_data !== 24'h800000 || p1_wr_addr !== 4'd0) begin
                    errors++;
                    $display("FAIL single_write: addr=%0d data=%h required 0 800000", p1_wr_addr, p1_wr_data);
                end
            end
        end
    endtask

    task automatic test_checksum;
        @(negedge clk); p2_start = 1'b1;
        @(negedge clk); p2_start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 4) begin
                checks++;
                if (p2_wr_en !== 1'b1 || p2_wr_addr !== 1'b1 || p2_wr_data !== 24'h000002) begin
                    errors++;
                    $display("FAIL csum_last_write: en=%b addr=%0d data=%h required 1 1 000002", p2_wr_en, p2_wr_addr, p2_wr_data);
                end
            end
            if (c == 5) begin
                checks++;
                if (p2_done !== 1'b1 || p2_checksum !== c_EXP_SUM) begin
                    errors++;
                    $display("FAIL csum_done: done=%b checksum=%h required 1 %h", p2_done, p2_checksum, c_EXP_SUM);
                end
            end
        end
        checks++;
        if (p2_checksum !== c_EXP_SUM) begin
            errors++;
            $display("FAIL csum_hold: checksum=%h required %h", p2_checksum, c_EXP_SUM);
        end
        // A new launch clears the sum before any new write lands.
        @(negedge clk); p2_start = 1'b1;
        @(negedge clk); p2_start = 1'b0;
        checks++;
        if (p2_checksum !== 24'h000000) begin
            errors++;
            $display("FAIL csum_clear: checksum=%h required 000000", p2_checksum);
        end
        for (int c = 2; c <= 6; c++) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mix16[i] = 24'h5A0000 + 24'(i) * 24'h010203;
            key16[i] = 24'h000000;
        end
        mix4[0] = 24'hFF0000; key4[0] = 24'hFF0000; exp4[0] = 24'h000000;
        mix4[1] = 24'h00FF00; key4[1] = 24'h0000FF; exp4[1] = 24'h00FFFF;
        mix4[2] = 24'h123456; key4[2] = 24'h123456; exp4[2] = 24'h000000;
        mix4[3] = 24'hABCDEF; key4[3] = 24'h000000; exp4[3] = 24'hABCDEF;

        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_reset_mid_image;
        test_full_range;
        test_basic;
        test_back_to_back;
        test_single;
        test_checksum;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
